max_seq_ctrl: RTL
=================

Name: max_seq_ctrl

Overview:
Sequencer that feeds a row of up to MAX_LEN 16-bit scores from the row buffer into max_module in 64-lane beats. It generates per-beat lane-valid masks and drives the tree's length mode and enable. It folds the per-beat 64-lane maxima into one row maximum and returns it to the softmax control path through a valid/ready handshake.

Parameters:
MAX_LEN, 1024, maximum row length in elements (multiple of 64)
RD_LAT, 2, row-buffer read latency in cycles (>=1)
TREE_LAT, 8, max_module latency, i_valid to o_valid_max
TIMEOUT, 64, cycles allowed after last issue for all beat results to return

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_row_len  in  11  row length in elements
i_length_mode  in  4  length mode passed to max_module, latched at start
o_busy  out  1  high in every state except IDLE
o_rd_en  out  1  row-buffer read strobe
o_rd_addr  out  4  beat index to read
i_rd_data  in  1024  read data, valid RD_LAT cycles after o_rd_en
o_mx_en  out  1  max_module i_en
o_mx_length_mode  out  4  max_module i_length_mode
o_mx_valid  out  64  max_module i_valid lane mask
o_mx_in_flat  out  1024  max_module i_in_flat
i_mx_valid_max  in  1  max_module o_valid_max
i_mx_max64  in  16  max_module o_max64_0
o_res_valid  out  1  result valid
i_res_ready  in  1  result accept
o_res_max  out  16  row maximum, signed two's complement
o_res_err  out  1  length error or timeout

Behaviour:
Interface:
- One clock, i_clk.
- Reset is asynchronous and active-low on i_rst_n.

Reset values:
- All outputs 0 except o_res_max = 16'h8000.
- FSM returns to IDLE.
- Reset mid-row aborts the row; no result is emitted.

States:
- IDLE:
  - i_start latches len and mode.
  - nb = ceil(len/64).
  - len==0 or len>MAX_LEN: go to DONE with err=1, max=16'h8000.
  - Otherwise: go to ISSUE with beat=0, ret=0, acc=16'h8000.
- ISSUE:
  - o_rd_en=1, o_rd_addr=beat, beat++ each cycle.
  - After beat nb-1 is issued, go to DRAIN and clear the watchdog counter.
- DRAIN:
  - Counter increments each cycle.
  - When ret==nb, go to DONE.
  - If the counter reaches TIMEOUT first, go to DONE with err=1 and acc as accumulated so far.
- DONE:
  - o_res_valid=1; o_res_max and o_res_err held stable.
  - On i_res_valid & i_res_ready, go to IDLE the same cycle.
  - i_start is ignored outside IDLE.

Issue pipeline:
- An RD_LAT-deep shift register carries {issued, last} alongside the read.
- When it emerges, o_mx_in_flat = i_rd_data.
- o_mx_valid is all ones, except on the last beat when len%64 != 0: there it is (1<<(len%64))-1.
- Bubble cycles drive o_mx_valid=0; tree lanes with valid 0 must not contribute.
- o_mx_en = 1 from leaving IDLE until DONE, so the tree pipeline flushes.
- o_mx_length_mode = latched mode.

Accumulation:
- On each i_mx_valid_max while in ISSUE or DRAIN: acc = signed-max(acc, i_mx_max64), ret++.
- i_mx_valid_max seen in IDLE or DONE is ignored.
- Equal values leave acc unchanged.
- The compare is strictly signed 16-bit, e.g. 16'hFFFF < 16'h0001.

Latency:
- Back-to-back issue, one beat per cycle.
- Result latency from start ≈ 1 + nb + RD_LAT + TREE_LAT cycles.

Decomposition:
- Shared package (softmax_pkg):
  - DATA_W=16, LANES=64, MAX_LEN, the row-length width
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - NEG_MAX=16'h8000
  - the function lane_mask(len) returning the 64-bit last-beat mask
- Sub-module: max_seq_rdpipe, the RD_LAT-deep valid/last delay line with data capture. The FSM and accumulator stay in the top module.

Test Plan:
- len=64, lanes 0..63 = k-32, mode 4'h6 -> one rd_en at addr 0, o_mx_valid=all ones, o_mx_length_mode=6, res_max=16'h001F, err=0.
- len=130, lane 1 of beat 2 = 16'h7FFF, lane 5 of beat 2 = 16'h7FFF+masked, all else 0 -> 3 reads at addr 0,1,2; last mask 64'h3; res_max=16'h7FFF; a value in a masked lane never wins.
- len=0 and len=1025 -> no rd_en; res_valid within 2 cycles with err=1, max=16'h8000.
- All-negative row, len=1024, values in 16'h8001..16'hFFFE -> 16 consecutive reads; res_max=16'hFFFE.
- i_res_ready held low 10 cycles with i_start pulsed -> result stable, start ignored, busy=1; ready high -> IDLE next cycle.
- Model suppresses one i_mx_valid_max -> err=1 after TIMEOUT cycles of DRAIN. Separately, drop i_rst_n mid-ISSUE -> all outputs at reset values immediately, and no result after release.

Source files
------------

// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_pkg
//  Description : Shared types, widths and helpers for the softmax max-reduce
//                sequencer and its read pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

    localparam int DATA_W  = 16;
    localparam int LANES   = 64;
    localparam int MAX_LEN = 1024;
    localparam int LEN_W   = 11;
    localparam int ADDR_W  = 4;
    localparam int BEAT_W  = 5;
    localparam int FLAT_W  = DATA_W * LANES;

    localparam logic [DATA_W-1:0] NEG_MAX = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Lane-valid mask for the final beat of a row: a partial beat keeps only
    // its low len%64 lanes, a full beat keeps all of them.
    function automatic logic [LANES-1:0] lane_mask(input logic [LEN_W-1:0] len);
        logic [5:0] rem;
        rem = len[5:0];
        if (rem == 6'd0) begin
            return '1;
        end
        return (64'd1 << rem) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_seq_rdpipe.sv
`default_nettype none
// ============================================================================
//  Module      : max_seq_rdpipe
//  Description : Delays the issue/last flags by the row-buffer read latency
//                and captures the returning beat together with its lane mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_seq_rdpipe
    import softmax_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              last,
    input  logic [LANES-1:0]  last_mask,
    input  logic [FLAT_W-1:0] rd_data,
    output logic [LANES-1:0]  mx_valid,
    output logic [FLAT_W-1:0] mx_in_flat
);

    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] last_sr;
    logic              emerge;
    logic              emerge_last;

    generate
        if (RD_LAT == 1) begin : g_lat_one
            // Single-stage delay: the flags simply follow the read strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr  <= '0;
                    last_sr <= '0;
                end else begin
                    vld_sr  <= issue;
                    last_sr <= last;
                end
            end
        end else begin : g_lat_multi
            // Multi-stage delay line tracking each outstanding read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr  <= '0;
                    last_sr <= '0;
                end else begin
                    vld_sr  <= {vld_sr[RD_LAT-2:0], issue};
                    last_sr <= {last_sr[RD_LAT-2:0], last};
                end
            end
        end
    endgenerate

    assign emerge      = vld_sr[RD_LAT-1];
    assign emerge_last = last_sr[RD_LAT-1];

    // Register the returning beat; bubble cycles present an empty lane mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx_valid   <= '0;
            mx_in_flat <= '0;
        end else if (emerge) begin
            mx_valid   <= emerge_last ? last_mask : '1;
            mx_in_flat <= rd_data;
        end else begin
            mx_valid   <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/max_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : max_seq_ctrl
//  Description : Streams a score row into the 64-lane max tree beat by beat,
//                folds the per-beat maxima into a row maximum and returns it
//                over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int MAX_LEN  = softmax_pkg::MAX_LEN,
    parameter int RD_LAT   = 2,
    parameter int TREE_LAT = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [10:0]       i_row_len,
    input  logic [3:0]        i_length_mode,
    output logic              o_busy,
    output logic              o_rd_en,
    output logic [3:0]        o_rd_addr,
    input  logic [FLAT_W-1:0] i_rd_data,
    output logic              o_mx_en,
    output logic [3:0]        o_mx_length_mode,
    output logic [LANES-1:0]  o_mx_valid,
    output logic [FLAT_W-1:0] o_mx_in_flat,
    input  logic              i_mx_valid_max,
    input  logic [15:0]       i_mx_max64,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [15:0]       o_res_max,
    output logic              o_res_err
);

    // The watchdog never fires before a beat could possibly have returned,
    // even if TIMEOUT is configured below the fixed read + tree latency.
    localparam int WD_FLOOR = RD_LAT + TREE_LAT + 2;
    localparam int WD_MAX   = (TIMEOUT > WD_FLOOR) ? TIMEOUT : WD_FLOOR;
    localparam int WD_W     = $clog2(WD_MAX + 1);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seq_state_t        state;
    logic [BEAT_W-1:0] nb;
    logic [ADDR_W-1:0] nb_last;
    logic [BEAT_W-1:0] ret;
    logic [WD_W-1:0]   wd;
    logic [LANES-1:0]  last_mask;
    logic [DATA_W-1:0] acc;
    logic              err;

    logic [BEAT_W-1:0] start_nb;
    logic [ADDR_W-1:0] start_nb_last;
    logic              len_bad;
    logic              issue_last;
    logic              mx_hit;
    logic              mx_greater;

    assign start_nb      = i_row_len[LEN_W-1:6] + BEAT_W'(|i_row_len[5:0]);
    assign start_nb_last = i_row_len[9:6] + ADDR_W'(|i_row_len[5:0]) - ADDR_W'(1);
    assign len_bad       = (i_row_len == '0) || (i_row_len > MAX_LEN_L);
    assign issue_last    = o_rd_en && (o_rd_addr == nb_last);
    assign mx_hit        = i_mx_valid_max && ((state == ISSUE) || (state == DRAIN));
    assign mx_greater    = $signed(i_mx_max64) > $signed(acc);

    assign o_res_max = acc;
    assign o_res_err = err;

    // Sequencer FSM with row accumulator; every output is registered here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            o_busy           <= 1'b0;
            o_rd_en          <= 1'b0;
            o_rd_addr        <= '0;
            o_mx_en          <= 1'b0;
            o_mx_length_mode <= '0;
            o_res_valid      <= 1'b0;
            nb               <= '0;
            nb_last          <= '0;
            ret              <= '0;
            wd               <= '0;
            last_mask        <= '0;
            acc              <= NEG_MAX;
            err              <= 1'b0;
        end else begin
            if (mx_hit) begin
                ret <= ret + BEAT_W'(1);
                if (mx_greater) begin
                    acc <= i_mx_max64;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_mx_length_mode <= i_length_mode;
                        last_mask        <= lane_mask(i_row_len);
                        nb               <= start_nb;
                        nb_last          <= start_nb_last;
                        ret              <= '0;
                        wd               <= '0;
                        acc              <= NEG_MAX;
                        o_busy           <= 1'b1;
                        if (len_bad) begin
                            err         <= 1'b1;
                            o_res_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            err       <= 1'b0;
                            o_rd_en   <= 1'b1;
                            o_rd_addr <= '0;
                            o_mx_en   <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (issue_last) begin
                        o_rd_en <= 1'b0;
                        wd      <= '0;
                        state   <= DRAIN;
                    end else begin
                        o_rd_addr <= o_rd_addr + ADDR_W'(1);
                    end
                end

                DRAIN: begin
                    wd <= wd + WD_W'(1);
                    if (ret == nb) begin
                        o_res_valid <= 1'b1;
                        o_mx_en     <= 1'b0;
                        state       <= DONE;
                    end else if (wd == WD_W'(WD_MAX - 1)) begin
                        err         <= 1'b1;
                        o_res_valid <= 1'b1;
                        o_mx_en     <= 1'b0;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (o_res_valid && i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    max_seq_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .issue      (o_rd_en),
        .last       (issue_last),
        .last_mask  (last_mask),
        .rd_data    (i_rd_data),
        .mx_valid   (o_mx_valid),
        .mx_in_flat (o_mx_in_flat)
    );

endmodule
`default_nettype wire
